// File: rtl/svm_ctrl_pkg.sv
// Shared types and constants for the SVM sliding-window controller.
package svm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    ISSUE,
    DRAIN
  } ctrl_state_e;

  // Fixed-point split of the feature words fed to the SVM lanes.
  localparam int FEA_I = 4;
  localparam int FEA_F = 28;

endpackage

// File: rtl/svm_window_ctrl_if.sv
// Block-buffer read / SVM beat / SVM result bus between controller and datapath.
interface svm_window_ctrl_if #(
  parameter int AW   = 9,
  parameter int SW_W = 11
);

  logic            svm_ready;
  logic            rd_en;
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  logic [AW-1:0]   rd_addr_c;
  logic [AW-1:0]   rd_addr_d;
  logic            svm_i_valid;
  logic [SW_W-1:0] svm_sw_id;
  logic            res_valid;
  logic            res_is_person;
  logic [SW_W-1:0] res_sw_id;

  modport master (
    input  svm_ready, res_valid, res_is_person, res_sw_id,
    output rd_en, rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d,
    output svm_i_valid, svm_sw_id
  );

  modport slave (
    output svm_ready, res_valid, res_is_person, res_sw_id,
    input  rd_en, rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d,
    input  svm_i_valid, svm_sw_id
  );

endinterface

// File: rtl/svm_win_addr_gen.sv
// Window/beat position tracker producing four lane addresses per beat with adders only.
module svm_win_addr_gen #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 32,
  parameter int WIN_W  = 8,
  parameter int WIN_H  = 16,
  parameter int AW     = 9,
  parameter int SW_W   = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            beat_adv_i,
  input  logic            win_adv_i,
  output logic [AW-1:0]   addr_a_o,
  output logic [AW-1:0]   addr_b_o,
  output logic [AW-1:0]   addr_c_o,
  output logic [AW-1:0]   addr_d_o,
  output logic [SW_W-1:0] sw_id_o,
  output logic            last_beat_o,
  output logic            last_win_o
);

  localparam int NWX   = GRID_W - WIN_W + 1;
  localparam int NWIN  = NWX * (GRID_H - WIN_H + 1);
  localparam int BEATS = WIN_W * WIN_H / 4;
  localparam int BW    = $clog2(BEATS) + 1;
  localparam int CW    = $clog2(WIN_W) + 1;
  localparam int XW    = $clog2(NWX) + 1;
  localparam logic [AW-1:0] ROW_JUMP = AW'(GRID_W - WIN_W + 1);

  logic [AW-1:0]   base_q;
  logic [XW-1:0]   wx_q;
  logic [SW_W-1:0] sw_id_q;
  logic [BW-1:0]   beat_q;
  logic [CW-1:0]   col0_q;
  logic [AW-1:0]   off0_q;

  logic [CW-1:0]   lane_col [5];
  logic [AW-1:0]   lane_off [5];

  // Each lane is the previous one stepped by one local block; entry 4 is the next beat's origin.
  always_comb begin
    lane_col[0] = col0_q;
    lane_off[0] = off0_q;
    for (int unsigned j = 0; j < 4; j++) begin
      if (lane_col[j] == CW'(WIN_W - 1)) begin
        lane_col[j+1] = '0;
        lane_off[j+1] = lane_off[j] + ROW_JUMP;
      end else begin
        lane_col[j+1] = lane_col[j] + CW'(1);
        lane_off[j+1] = lane_off[j] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      wx_q    <= '0;
      sw_id_q <= '0;
      beat_q  <= '0;
      col0_q  <= '0;
      off0_q  <= '0;
    end else if (clr_i) begin
      base_q  <= '0;
      wx_q    <= '0;
      sw_id_q <= '0;
      beat_q  <= '0;
      col0_q  <= '0;
      off0_q  <= '0;
    end else if (win_adv_i) begin
      beat_q  <= '0;
      col0_q  <= '0;
      off0_q  <= '0;
      sw_id_q <= sw_id_q + SW_W'(1);
      if (wx_q == XW'(NWX - 1)) begin
        wx_q   <= '0;
        base_q <= base_q + AW'(WIN_W);
      end else begin
        wx_q   <= wx_q + XW'(1);
        base_q <= base_q + AW'(1);
      end
    end else if (beat_adv_i) begin
      beat_q <= beat_q + BW'(1);
      col0_q <= lane_col[4];
      off0_q <= lane_off[4];
    end
  end

  assign addr_a_o    = base_q + lane_off[0];
  assign addr_b_o    = base_q + lane_off[1];
  assign addr_c_o    = base_q + lane_off[2];
  assign addr_d_o    = base_q + lane_off[3];
  assign sw_id_o     = sw_id_q;
  assign last_beat_o = (beat_q == BW'(BEATS - 1));
  assign last_win_o  = (sw_id_q == SW_W'(NWIN - 1));

endmodule

// File: rtl/svm_window_ctrl.sv
// Sliding-window scan controller feeding block-buffer reads and SVM beats.
// Optional SVM_CTRL_PERF_EN adds a saturating stall_cnt output.
module svm_window_ctrl
  import svm_ctrl_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 32,
  parameter int WIN_W  = 8,
  parameter int WIN_H  = 16,
  parameter int SW_W   = 11,
  parameter int AW     = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            frame_done,
  output logic            det_valid,
  output logic [SW_W-1:0] det_sw_id,
  output logic [SW_W:0]   det_cnt,
  svm_window_ctrl_if.master bus
`ifdef SVM_CTRL_PERF_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int NWIN = (GRID_W - WIN_W + 1) * (GRID_H - WIN_H + 1);
  localparam logic [SW_W:0] NWIN_C = (SW_W + 1)'(NWIN);

  ctrl_state_e state_q, state_d;

  logic            clr, beat_adv, win_adv;
  logic            last_beat, last_win;
  logic            rd_en, start_acc, res_done, hit;
  logic [AW-1:0]   addr_a, addr_b, addr_c, addr_d;
  logic [SW_W-1:0] sw_id;

  logic            vld_q;
  logic [SW_W-1:0] vld_id_q;
  logic [SW_W:0]   res_cnt_q;
  logic            det_valid_q;
  logic [SW_W-1:0] det_sw_id_q;
  logic [SW_W:0]   det_cnt_q;

  svm_win_addr_gen #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .WIN_W  (WIN_W),
    .WIN_H  (WIN_H),
    .AW     (AW),
    .SW_W   (SW_W)
  ) u_addr (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .beat_adv_i  (beat_adv),
    .win_adv_i   (win_adv),
    .addr_a_o    (addr_a),
    .addr_b_o    (addr_b),
    .addr_c_o    (addr_c),
    .addr_d_o    (addr_d),
    .sw_id_o     (sw_id),
    .last_beat_o (last_beat),
    .last_win_o  (last_win)
  );

  assign start_acc = start && (state_q == IDLE);
  assign res_done  = (res_cnt_q >= NWIN_C);
  assign hit       = bus.res_valid && bus.res_is_person;

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    beat_adv = 1'b0;
    win_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.svm_ready) state_d = ISSUE;
      end
      ISSUE: begin
        if (!last_beat) begin
          beat_adv = 1'b1;
        end else if (last_win) begin
          state_d = DRAIN;
        end else begin
          win_adv = 1'b1;
          state_d = WAIT_RDY;
        end
      end
      DRAIN: begin
        if (res_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The beat tag trails rd_en by one cycle to line up with the buffer read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      vld_id_q <= '0;
    end else begin
      vld_q    <= rd_en;
      vld_id_q <= sw_id;
    end
  end

  // Result counter saturates at the window total so a frame end is never missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt_q   <= '0;
      det_valid_q <= 1'b0;
      det_sw_id_q <= '0;
      det_cnt_q   <= '0;
    end else begin
      det_valid_q <= hit;
      if (hit) det_sw_id_q <= bus.res_sw_id;
      if (start_acc) begin
        res_cnt_q <= '0;
        det_cnt_q <= '0;
      end else begin
        if (bus.res_valid && !res_done) res_cnt_q <= res_cnt_q + (SW_W + 1)'(1);
        if (hit) det_cnt_q <= det_cnt_q + (SW_W + 1)'(1);
      end
    end
  end

`ifdef SVM_CTRL_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (start_acc) begin
      stall_cnt_q <= '0;
    end else if (state_q == WAIT_RDY && !bus.svm_ready && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign rd_en           = (state_q == ISSUE);
  assign bus.rd_en       = rd_en;
  assign bus.rd_addr_a   = rd_en ? addr_a : '0;
  assign bus.rd_addr_b   = rd_en ? addr_b : '0;
  assign bus.rd_addr_c   = rd_en ? addr_c : '0;
  assign bus.rd_addr_d   = rd_en ? addr_d : '0;
  assign bus.svm_i_valid = vld_q;
  assign bus.svm_sw_id   = vld_id_q;

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DRAIN) && res_done;
  assign det_valid  = det_valid_q;
  assign det_sw_id  = det_sw_id_q;
  assign det_cnt    = det_cnt_q;

endmodule

// File: tb/tb_svm_window_ctrl.sv
// Scoreboard bench: small 4x4/2x2 instance for protocol cases, default instance for full-size scan.
module tb_svm_window_ctrl;

  localparam int GW = 4, GH = 4, WW = 2, WH = 2, SWW = 4, AWS = 4;
  localparam int NWX = GW - WW + 1;
  localparam int NWIN = NWX * (GH - WH + 1);
  localparam int NBEATS = WW * WH / 4;
  localparam int DGW = 16, DWW = 8, DNWX = 9, DNWIN = 153, DBEATS = 32;

  logic clk = 1'b0;
  logic rst, start, start2;
  always #5 clk = ~clk;

  logic            busy, frame_done, det_valid;
  logic [SWW-1:0]  det_sw_id;
  logic [SWW:0]    det_cnt;
  logic            busy2, frame_done2, det_valid2;
  logic [10:0]     det_sw_id2;
  logic [11:0]     det_cnt2;
`ifdef SVM_CTRL_PERF_EN
  logic [15:0]     stall_cnt, stall_cnt2;
`endif

  svm_window_ctrl_if #(.AW(AWS), .SW_W(SWW)) bus ();
  svm_window_ctrl_if #(.AW(9), .SW_W(11)) bus2 ();

  svm_window_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .WIN_W(WW), .WIN_H(WH), .SW_W(SWW), .AW(AWS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .det_valid(det_valid), .det_sw_id(det_sw_id), .det_cnt(det_cnt), .bus(bus)
`ifdef SVM_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  svm_window_ctrl dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .frame_done(frame_done2),
    .det_valid(det_valid2), .det_sw_id(det_sw_id2), .det_cnt(det_cnt2), .bus(bus2)
`ifdef SVM_CTRL_PERF_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  typedef struct { int a; int b; int c; int d; int id; } beat_t;
  typedef struct { int id; int cnt; } det_t;

  beat_t exp_q[$];
  int    sw_q[$];
  det_t  det_q[$];

  int n_checks = 0, n_pass = 0;
  int n_done = 0, n_det = 0, exp_det = 0;
  int n_done2 = 0, m_w = 0, m_b = 0, vcount = 0, last_id2 = 0;
  logic [35:0] last_pk2 = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int addr_of(input int gw, input int ww, input int wx, input int wy, input int k);
    return (wy + k / ww) * gw + wx + k % ww;
  endfunction

  function automatic logic [35:0] pk(input int a, input int b, input int c, input int d);
    return {a[8:0], b[8:0], c[8:0], d[8:0]};
  endfunction

  task automatic push_windows(input int count);
    for (int w = 0; w < count; w++) begin
      for (int b = 0; b < NBEATS; b++) begin
        beat_t e;
        e.id = w;
        e.a  = addr_of(GW, WW, w % NWX, w / NWX, 4 * b);
        e.b  = addr_of(GW, WW, w % NWX, w / NWX, 4 * b + 1);
        e.c  = addr_of(GW, WW, w % NWX, w / NWX, 4 * b + 2);
        e.d  = addr_of(GW, WW, w % NWX, w / NWX, 4 * b + 3);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor for the small instance
  initial begin
    int prev_rd;
    beat_t e;
    det_t d;
    prev_rd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rd = 0;
      end else begin
        if (bus.svm_i_valid) begin
          chk("valid_follows_rd_en", prev_rd, 1);
          if (sw_q.size() == 0) chk("svm_sw_id_unexpected", sw_q.size(), 1);
          else chk("svm_sw_id", bus.svm_sw_id, sw_q.pop_front());
        end
        if (bus.rd_en) begin
          if (exp_q.size() == 0) begin
            chk("rd_en_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("rd_addr_a", bus.rd_addr_a, e.a);
            chk("rd_addr_b", bus.rd_addr_b, e.b);
            chk("rd_addr_c", bus.rd_addr_c, e.c);
            chk("rd_addr_d", bus.rd_addr_d, e.d);
            sw_q.push_back(e.id);
          end
        end
        if (det_valid) begin
          n_det++;
          if (det_q.size() == 0) begin
            chk("det_valid_unexpected", det_q.size(), 1);
          end else begin
            d = det_q.pop_front();
            chk("det_sw_id", det_sw_id, d.id);
            chk("det_cnt_at_det", det_cnt, d.cnt);
          end
        end
        if (frame_done) n_done++;
        prev_rd = int'(bus.rd_en);
      end
    end
  end

  // SVM model for the small instance: result returns one cycle after each beat
  initial begin
    int pend_v, pend_id;
    pend_v = 0;
    pend_id = 0;
    bus.res_valid = 1'b0;
    bus.res_is_person = 1'b0;
    bus.res_sw_id = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_v = 0;
        bus.res_valid = 1'b0;
        bus.res_is_person = 1'b0;
      end else begin
        bus.res_valid = (pend_v != 0);
        bus.res_sw_id = SWW'(pend_id);
        bus.res_is_person = (pend_v != 0) && (pend_id == 2 || pend_id == 7);
        if (bus.res_is_person) begin
          exp_det++;
          det_q.push_back('{pend_id, exp_det});
        end
        pend_v = int'(bus.svm_i_valid);
        pend_id = int'(bus.svm_sw_id);
      end
    end
  end

  // Monitor and SVM model for the default-size instance
  initial begin
    bus2.res_valid = 1'b0;
    bus2.res_is_person = 1'b0;
    bus2.res_sw_id = '0;
    forever begin
      @(negedge clk);
      bus2.res_valid = 1'b0;
      if (!rst) begin
        if (bus2.svm_i_valid) begin
          if (vcount % DBEATS == 0) chk("dflt_sw_id", bus2.svm_sw_id, vcount / DBEATS);
          if (vcount % DBEATS == DBEATS - 1) begin
            bus2.res_valid = 1'b1;
            bus2.res_sw_id = bus2.svm_sw_id;
          end
          last_id2 = int'(bus2.svm_sw_id);
          vcount++;
        end
        if (bus2.rd_en) begin
          last_pk2 = {bus2.rd_addr_a, bus2.rd_addr_b, bus2.rd_addr_c, bus2.rd_addr_d};
          chk("dflt_addr", last_pk2,
              pk(addr_of(DGW, DWW, m_w % DNWX, m_w / DNWX, 4 * m_b),
                 addr_of(DGW, DWW, m_w % DNWX, m_w / DNWX, 4 * m_b + 1),
                 addr_of(DGW, DWW, m_w % DNWX, m_w / DNWX, 4 * m_b + 2),
                 addr_of(DGW, DWW, m_w % DNWX, m_w / DNWX, 4 * m_b + 3)));
          m_b++;
          if (m_b == DBEATS) begin
            m_b = 0;
            m_w++;
          end
        end
        if (frame_done2) n_done2++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    bus.svm_ready = 1'b1;
    bus2.svm_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", bus.rd_en, 0);
    chk("reset_svm_i_valid", bus.svm_i_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_det_valid", det_valid, 0);
    chk("reset_det_cnt", det_cnt, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Full frame with a 5-cycle stall before window 3 and an ignored mid-frame start
    exp_det = 0;
    push_windows(NWIN);
    pulse_start();
    t = 0;
    while (exp_q.size() != NWIN - 3 && t < 100) begin @(negedge clk); #1; t++; end
    chk("timeout_window2", t, t < 100 ? t : -1);
    bus.svm_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("stall_no_rd_en", bus.rd_en, 0);
    end
    bus.svm_ready = 1'b1;
    t = 0;
    while (exp_q.size() != NWIN - 6 && t < 100) begin @(negedge clk); #1; t++; end
    chk("timeout_window5", t, t < 100 ? t : -1);
    pulse_start();
    t = 0;
    while (n_done == 0 && t < 200) begin @(negedge clk); #1; t++; end
    chk("timeout_frame1", t, t < 200 ? t : -1);
    repeat (3) begin @(negedge clk); #1; end
    chk("frame1_done_pulses", n_done, 1);
    chk("frame1_busy", busy, 0);
    chk("frame1_det_cnt", det_cnt, 2);
    chk("frame1_det_pulses", n_det, 2);
    chk("frame1_beats_left", exp_q.size(), 0);
    chk("frame1_ids_left", sw_q.size(), 0);
    chk("frame1_dets_left", det_q.size(), 0);
`ifdef SVM_CTRL_PERF_EN
    chk("frame1_stall_cnt", stall_cnt, 5);
`endif

    // Asynchronous reset while window 4 is being read
    exp_det = 0;
    n_det = 0;
    n_done = 0;
    push_windows(5);
    pulse_start();
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); #1; t++; end
    chk("timeout_window4", t, t < 100 ? t : -1);
    chk("window4_rd_en_before_rst", bus.rd_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr_a", bus.rd_addr_a, 0);
    chk("rst_rd_addr_b", bus.rd_addr_b, 0);
    chk("rst_rd_addr_c", bus.rd_addr_c, 0);
    chk("rst_rd_addr_d", bus.rd_addr_d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_svm_i_valid", bus.svm_i_valid, 0);
    chk("rst_svm_sw_id", bus.svm_sw_id, 0);
    chk("rst_det_valid", det_valid, 0);
    chk("rst_det_cnt", det_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    sw_q.delete();
    det_q.delete();
    exp_q.delete();
    exp_det = 0;
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_idle", busy, 0);

    // Restart after reset begins again at window 0
    n_det = 0;
    n_done = 0;
    push_windows(NWIN);
    pulse_start();
    t = 0;
    while (n_done == 0 && t < 200) begin @(negedge clk); #1; t++; end
    chk("timeout_frame2", t, t < 200 ? t : -1);
    repeat (3) begin @(negedge clk); #1; end
    chk("frame2_done_pulses", n_done, 1);
    chk("frame2_busy", busy, 0);
    chk("frame2_det_cnt", det_cnt, 2);
    chk("frame2_det_pulses", n_det, 2);
    chk("frame2_beats_left", exp_q.size(), 0);
    chk("frame2_ids_left", sw_q.size(), 0);
`ifdef SVM_CTRL_PERF_EN
    chk("frame2_stall_cnt", stall_cnt, 0);
`endif

    // Default geometry: 153 windows of 32 beats
    start2 = 1'b1;
    @(negedge clk); #1;
    start2 = 1'b0;
    t = 0;
    while (n_done2 == 0 && t < 6000) begin @(negedge clk); #1; t++; end
    chk("timeout_dflt_frame", t, t < 6000 ? t : -1);
    repeat (3) begin @(negedge clk); #1; end
    chk("dflt_windows", m_w, DNWIN);
    chk("dflt_partial_beats", m_b, 0);
    chk("dflt_total_valid_beats", vcount, DNWIN * DBEATS);
    chk("dflt_last_sw_id", last_id2, DNWIN - 1);
    chk("dflt_last_addrs", last_pk2,
        pk(addr_of(DGW, DWW, 8, 16, 124), addr_of(DGW, DWW, 8, 16, 125),
           addr_of(DGW, DWW, 8, 16, 126), addr_of(DGW, DWW, 8, 16, 127)));
    chk("dflt_done_pulses", n_done2, 1);
    chk("dflt_busy", busy2, 0);
    chk("dflt_det_cnt", det_cnt2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
